// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: snoops 8080-style LCD write bus into a byte FIFO and tracks RAMWR bursts
module lcd_bus_rx #(
    parameter int         DEPTH_LOG2 = 2,
    parameter logic [7:0] RAMWR_CMD  = 8'h2C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_d_i,
    input  logic       lcd_rs_i,
    input  logic       lcd_wr_n_i,
    input  logic       lcd_cs_n_i,
    output logic [7:0] out_data,
    output logic       out_rs,
    output logic       out_first,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ramwr_active,
    output logic       ovf,
    input  logic       ovf_clr
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, BURST} state_t;

    logic [7:0] d_s1, d_s2, d_s3;
    logic rs_s1, rs_s2, rs_s3;
    logic wr_s1, wr_s2, wr_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic wr_edge, cs_fall, cs_rise;
    logic first_q;
    logic [9:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp, rp;
    logic [DEPTH_LOG2:0] cnt;
    logic full, pop, push, drop;
    state_t state, state_nx;

    // Chains restart as an idle bus so a strobe caught across reset is never captured
    always_ff @(posedge clk) begin
        if (rst) begin
            {d_s1, d_s2, d_s3} <= '0;
            {rs_s1, rs_s2, rs_s3} <= '0;
            {wr_s1, wr_s2, wr_s3} <= '1;
            {cs_s1, cs_s2, cs_s3} <= '1;
        end else begin
            {d_s3, d_s2, d_s1} <= {d_s2, d_s1, lcd_d_i};
            {rs_s3, rs_s2, rs_s1} <= {rs_s2, rs_s1, lcd_rs_i};
            {wr_s3, wr_s2, wr_s1} <= {wr_s2, wr_s1, lcd_wr_n_i};
            {cs_s3, cs_s2, cs_s1} <= {cs_s2, cs_s1, lcd_cs_n_i};
        end
    end

    assign wr_edge = wr_s2 & ~wr_s3 & ~cs_s2;
    assign cs_fall = ~cs_s2 & cs_s3;
    assign cs_rise = cs_s2 & ~cs_s3;

    // Count is one bit wider than the pointers, so its MSB alone marks full
    assign full = cnt[DEPTH_LOG2];
    assign pop  = out_valid & out_ready;
    assign push = wr_edge & (~full | pop);
    assign drop = wr_edge & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            first_q <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
            ovf <= drop | (ovf & ~ovf_clr);
            first_q <= cs_fall ? 1'b1 : wr_edge ? 1'b0 : first_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {first_q, rs_s3, d_s3};
    end

    assign out_valid = cnt != '0;
    assign {out_first, out_rs, out_data} = out_valid ? mem[rp] : 10'h000;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // Dropped bytes still steer the burst tracker: wr_edge, not push
    always_comb begin
        state_nx = cs_rise ? IDLE :
                   (wr_edge & ~rs_s3) ? (d_s3 == RAMWR_CMD ? BURST : IDLE) : state;
    end

    assign ramwr_active = state == BURST;
endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx: random and directed bus writes checked against a queue-based reference model
module tb_lcd_bus_rx;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] lcd_d = 8'h00;
    logic lcd_rs = 1'b0, lcd_wr_n = 1'b1, lcd_cs_n = 1'b1;
    logic rdy_man = 1'b0, rr = 1'b0, rand_rdy = 1'b0, ovf_clr = 1'b0;
    logic out_ready;
    logic [7:0] out_data;
    logic out_rs, out_first, out_valid, ramwr_active, ovf;

    assign out_ready = rand_rdy ? rr : rdy_man;

    lcd_bus_rx #(.DEPTH_LOG2(2), .RAMWR_CMD(8'h2C)) dut (
        .clk(clk), .rst(rst),
        .lcd_d_i(lcd_d), .lcd_rs_i(lcd_rs), .lcd_wr_n_i(lcd_wr_n), .lcd_cs_n_i(lcd_cs_n),
        .out_data(out_data), .out_rs(out_rs), .out_first(out_first),
        .out_valid(out_valid), .out_ready(out_ready),
        .ramwr_active(ramwr_active), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;
    logic [9:0] got[$];

    // Bus events the stimulus schedules for the clock at which the DUT should act on them
    int ev_at[4096];
    logic [1:0] ev_kind[4096];
    logic [7:0] ev_d[4096];
    logic ev_rs[4096];
    int ev_n = 0;

    int cyc = 0, ev_rd = 0, fall_at = -1;
    logic [9:0] q[$];
    logic [9:0] pe;
    bit movf = 0, mburst = 0, mfirst = 0, pop, push, drop;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            movf = 0;
            mburst = 0;
            mfirst = 0;
            ev_rd = ev_n;
            fall_at = lcd_cs_n ? -1 : cyc + 3;
        end else begin
            pop = q.size() != 0 && out_ready;
            push = 0;
            pe = '0;
            if (fall_at == cyc) mfirst = 1;
            while (ev_rd < ev_n && ev_at[ev_rd] == cyc) begin
                case (ev_kind[ev_rd])
                    2'd0: begin
                        push = 1;
                        pe = {mfirst, ev_rs[ev_rd], ev_d[ev_rd]};
                        mfirst = 0;
                        if (!ev_rs[ev_rd]) mburst = ev_d[ev_rd] == 8'h2C;
                    end
                    2'd1: mburst = 0;
                    default: mfirst = 1;
                endcase
                ev_rd++;
            end
            drop = push && q.size() == DEPTH && !pop;
            if (pop) void'(q.pop_front());
            if (push && !drop) q.push_back(pe);
            movf = drop ? 1 : ovf_clr ? 0 : movf;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            check("valid", out_valid, q.size() != 0);
            if (q.size() != 0) check("head", {out_first, out_rs, out_data}, q[0]);
            check("ovf", ovf, movf);
            check("ramwr", ramwr_active, mburst);
        end
        if (out_valid && out_ready) got.push_back({out_first, out_rs, out_data});
        @(posedge clk);
        #1;
        rr = $urandom_range(0, 2) != 0;
    endtask

    task automatic add_ev(input logic [1:0] kind, input logic [7:0] d, input logic rs);
        ev_at[ev_n] = cyc + 3;
        ev_kind[ev_n] = kind;
        ev_d[ev_n] = d;
        ev_rs[ev_n] = rs;
        ev_n++;
    endtask

    task automatic cs(input logic v);
        if (v != lcd_cs_n) add_ev(v ? 2'd1 : 2'd2, 8'h00, 1'b0);
        lcd_cs_n = v;
        repeat (3) step();
    endtask

    task automatic wr_byte(input logic rs, input logic [7:0] d, input bit pulse);
        lcd_rs = rs;
        lcd_d = d;
        lcd_wr_n = 1'b0;
        repeat (2) step();
        lcd_wr_n = 1'b1;
        if (!lcd_cs_n) add_ev(2'd0, d, rs);
        if (pulse) begin
            repeat (2) step();
            rdy_man = 1'b1;
            step();
            rdy_man = 1'b0;
        end else begin
            repeat (3) step();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_rs", out_rs, 0);
        check("rst_first", out_first, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ramwr", ramwr_active, 0);
        chk_en = 1;
        rst = 1'b0;
        step();

        cs(1'b0);
        rdy_man = 1'b1;
        wr_byte(1'b0, 8'h2C, 0);
        wr_byte(1'b1, 8'hA5, 0);
        repeat (3) step();
        check("t1_n", got.size(), 2);
        check("t1_b0", got.size() > 0 ? got[0] : 10'h3ff, 10'h22C);
        check("t1_b1", got.size() > 1 ? got[1] : 10'h3ff, 10'h1A5);
        check("t1_ramwr", ramwr_active, 1);

        cs(1'b1);
        got.delete();
        for (int i = 0; i < 10; i++) wr_byte(1'b0, 8'h2C, 0);
        check("t2_n", got.size(), 0);
        check("t2_valid", out_valid, 0);
        check("t2_ramwr", ramwr_active, 0);

        cs(1'b0);
        rdy_man = 1'b0;
        for (int i = 1; i <= 6; i++) wr_byte(1'b1, 8'(i), 0);
        check("t3_ovf", ovf, 1);
        rdy_man = 1'b1;
        repeat (8) step();
        check("t3_n", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t3_byte", got.size() > i ? got[i] : 10'h3ff, (i == 0 ? 10'h300 : 10'h100) + 10'(i + 1));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);

        rdy_man = 1'b0;
        for (int i = 0; i < 4; i++) wr_byte(1'b1, 8'h11 + 8'(i), 0);
        wr_byte(1'b1, 8'h15, 1);
        check("t4_ovf", ovf, 0);
        check("t4_valid", out_valid, 1);
        got.delete();
        rdy_man = 1'b1;
        repeat (8) step();
        check("t4_n", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t4_byte", got.size() > i ? got[i] : 10'h3ff, 10'h112 + 10'(i));

        wr_byte(1'b0, 8'h2C, 0);
        check("t5_on", ramwr_active, 1);
        wr_byte(1'b0, 8'h2A, 0);
        check("t5_off", ramwr_active, 0);
        wr_byte(1'b0, 8'h2C, 0);
        check("t5_rearm", ramwr_active, 1);
        cs(1'b1);
        check("t5_desel", ramwr_active, 0);

        cs(1'b0);
        rdy_man = 1'b0;
        wr_byte(1'b0, 8'h2C, 0);
        for (int i = 0; i < 3; i++) wr_byte(1'b1, 8'h40 + 8'(i), 0);
        check("t6_pre_valid", out_valid, 1);
        check("t6_pre_ramwr", ramwr_active, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", out_valid, 0);
        check("t6_ramwr", ramwr_active, 0);
        check("t6_ovf", ovf, 0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) cs(!lcd_cs_n);
            else begin
                ovf_clr = $urandom_range(0, 5) == 0;
                wr_byte(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 8'h2C : 8'($urandom), 0);
            end
        end
        ovf_clr = 1'b0;
        rand_rdy = 1'b0;
        rdy_man = 1'b1;
        repeat (8) step();
        check("end_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
